// File: rtl/spi_slave.sv
// spi_slave: memory-mapped SPI target for the MMIO bus at 0x80000060.
// Supports all four CPOL/CPHA modes with one-byte RX/TX holding registers.
// Optional feature macro: SPI_SLAVE_IRQ_EN adds a registered irq output and CTRL[3].
module spi_slave (
  input  logic        clk,
  input  logic        reset,
  input  logic        mmio_valid,
  input  logic        mmio_write,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  input  logic [3:0]  mmio_wstrb,
  output logic [31:0] mmio_rdata,
  output logic        mmio_ready,
  input  logic        spi_sck,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
`ifdef SPI_SLAVE_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [31:0] ADDR_CTRL   = 32'h8000_0060;
  localparam logic [31:0] ADDR_TXDATA = 32'h8000_0064;
  localparam logic [31:0] ADDR_RXDATA = 32'h8000_0068;
  localparam logic [31:0] ADDR_STATUS = 32'h8000_006C;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t      r_state;
  logic        r_sck_s1, r_sck_s2, r_sck_d;
  logic        r_cs_s1, r_cs_s2, r_cs_d;
  logic        r_mosi_s1, r_mosi_s2, r_mosi_d;
  logic        r_cpol, r_cpha, r_enable;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx_shift, r_rx_data;
  logic [7:0]  r_tx_shift, r_tx_hold;
  logic        r_rx_valid, r_tx_empty, r_overrun, r_busy;
  logic        r_miso_bit;

  logic        w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic        w_lead, w_trail, w_sample, w_shift;
  logic        w_acc, w_wr, w_rd, w_rx_read, w_ovr_clr, w_tx_write;
  logic        w_cs_active, w_irq_en;
  logic [7:0]  w_reload_byte;
  logic        w_unused;

`ifdef SPI_SLAVE_IRQ_EN
  logic        r_irq_en;
  assign w_irq_en = r_irq_en;
`else
  assign w_irq_en = 1'b0;
`endif

  assign w_unused = ^{mmio_wdata[31:3], mmio_wstrb[3:1]};

  // Edge detection on the synchronised pins
  assign w_sck_rise = r_sck_s2 & ~r_sck_d;
  assign w_sck_fall = ~r_sck_s2 & r_sck_d;
  assign w_cs_fall  = ~r_cs_s2 & r_cs_d;
  assign w_cs_rise  = r_cs_s2 & ~r_cs_d;
  assign w_lead     = r_cpol ? w_sck_fall : w_sck_rise;
  assign w_trail    = r_cpol ? w_sck_rise : w_sck_fall;
  assign w_sample   = r_cpha ? w_trail : w_lead;
  assign w_shift    = r_cpha ? w_lead : w_trail;

  assign w_cs_active   = (r_state == ST_ACTIVE);
  assign w_reload_byte = r_tx_empty ? 8'hFF : r_tx_hold;

  // Bus request decode
  assign w_acc      = mmio_valid && !mmio_ready;
  assign w_wr       = w_acc && mmio_write && mmio_wstrb[0];
  assign w_rd       = w_acc && !mmio_write;
  assign w_rx_read  = w_rd && (mmio_addr == ADDR_RXDATA);
  assign w_ovr_clr  = w_wr && (mmio_addr == ADDR_STATUS) && mmio_wdata[2];
  assign w_tx_write = w_wr && (mmio_addr == ADDR_TXDATA);

  // Two-flop synchronisers plus edge-detect copy for each pin
  always_ff @(posedge clk) begin
    if (reset) begin
      {r_sck_s1, r_sck_s2, r_sck_d}    <= 3'b000;
      {r_cs_s1, r_cs_s2, r_cs_d}       <= 3'b111;
      {r_mosi_s1, r_mosi_s2, r_mosi_d} <= 3'b000;
    end else begin
      {r_sck_s1, r_sck_s2, r_sck_d}    <= {spi_sck, r_sck_s1, r_sck_s2};
      {r_cs_s1, r_cs_s2, r_cs_d}       <= {spi_cs, r_cs_s1, r_cs_s2};
      {r_mosi_s1, r_mosi_s2, r_mosi_d} <= {spi_mosi, r_mosi_s1, r_mosi_s2};
    end
  end

  // Bus acknowledge, read mux and CTRL register
  always_ff @(posedge clk) begin
    if (reset) begin
      mmio_ready <= 1'b0;
      mmio_rdata <= 32'h0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_enable   <= 1'b0;
`ifdef SPI_SLAVE_IRQ_EN
      r_irq_en   <= 1'b0;
`endif
    end else begin
      mmio_ready <= w_acc;
      mmio_rdata <= 32'h0;
      if (w_rd) begin
        case (mmio_addr)
          ADDR_CTRL:   mmio_rdata <= {28'h0, w_irq_en, r_enable, r_cpha, r_cpol};
          ADDR_RXDATA: mmio_rdata <= {24'h0, r_rx_data};
          ADDR_STATUS: mmio_rdata <= {27'h0, r_busy, w_cs_active, r_overrun,
                                      r_tx_empty, r_rx_valid};
          default:     mmio_rdata <= 32'h0;
        endcase
      end
      if (w_wr && (mmio_addr == ADDR_CTRL)) begin
        r_cpol   <= mmio_wdata[0];
        r_cpha   <= mmio_wdata[1];
        r_enable <= mmio_wdata[2];
`ifdef SPI_SLAVE_IRQ_EN
        r_irq_en <= mmio_wdata[3];
`endif
      end
    end
  end

  // Transfer FSM, shift registers and holding-register flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_data  <= 8'h00;
      r_tx_shift <= 8'h00;
      r_tx_hold  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_empty <= 1'b1;
      r_overrun  <= 1'b0;
      r_busy     <= 1'b0;
      r_miso_bit <= 1'b0;
    end else begin
      // CPU-side clears go first so a same-cycle set from the engine wins
      if (w_rx_read) r_rx_valid <= 1'b0;
      if (w_ovr_clr) r_overrun  <= 1'b0;

      if (!r_enable) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 3'd0;
        r_busy    <= 1'b0;
      end else if (r_state == ST_IDLE) begin
        if (w_cs_fall) begin
          r_state    <= ST_ACTIVE;
          r_bit_cnt  <= 3'd0;
          r_tx_shift <= w_reload_byte;
          r_tx_empty <= 1'b1;
          if (!r_cpha) r_miso_bit <= w_reload_byte[7];
        end
      end else if (w_cs_rise) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 3'd0;
        r_busy    <= 1'b0;
      end else begin
        if (w_sample) begin
          r_rx_shift <= {r_rx_shift[6:0], r_mosi_d};
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          r_busy     <= 1'b1;
          if (r_bit_cnt == 3'd7) begin
            r_rx_data  <= {r_rx_shift[6:0], r_mosi_d};
            r_rx_valid <= 1'b1;
            r_busy     <= 1'b0;
            if (r_rx_valid && !w_rx_read) r_overrun <= 1'b1;
            if (r_cpha) begin
              r_tx_shift <= w_reload_byte;
              r_tx_empty <= 1'b1;
            end
          end
        end
        if (w_shift) begin
          if (r_cpha) begin
            r_miso_bit <= r_tx_shift[7];
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          end else if (r_bit_cnt == 3'd0) begin
            // bit_cnt wrapped: a full byte just completed, start the next one
            r_tx_shift <= w_reload_byte;
            r_tx_empty <= 1'b1;
            r_miso_bit <= w_reload_byte[7];
          end else begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            r_miso_bit <= r_tx_shift[6];
          end
        end
      end

      // CPU write after any reload: reload used the old byte, new byte stays pending
      if (w_tx_write) begin
        r_tx_hold  <= mmio_wdata[7:0];
        r_tx_empty <= 1'b0;
      end
    end
  end

  // Registered pin-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      spi_miso    <= r_miso_bit;
      spi_miso_oe <= r_enable && w_cs_active;
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  // Interrupt on pending RX byte or overrun
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= w_irq_en && r_enable && (r_rx_valid || r_overrun);
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave acting as the external SPI controller.
// Expected values are queued when stimulus is applied and popped at each check.
module tb_spi_slave;

  localparam logic [31:0] A_CTRL   = 32'h8000_0060;
  localparam logic [31:0] A_TXDATA = 32'h8000_0064;
  localparam logic [31:0] A_RXDATA = 32'h8000_0068;
  localparam logic [31:0] A_STATUS = 32'h8000_006C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mmio_valid = 1'b0;
  logic        mmio_write = 1'b0;
  logic [31:0] mmio_addr = 32'h0;
  logic [31:0] mmio_wdata = 32'h0;
  logic [3:0]  mmio_wstrb = 4'h0;
  logic [31:0] mmio_rdata;
  logic        mmio_ready;
  logic        spi_sck = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
`ifdef SPI_SLAVE_IRQ_EN
  logic        irq;
`endif

  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  int          vectors = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  spi_slave dut (
    .clk         (clk),
    .reset       (reset),
    .mmio_valid  (mmio_valid),
    .mmio_write  (mmio_write),
    .mmio_addr   (mmio_addr),
    .mmio_wdata  (mmio_wdata),
    .mmio_wstrb  (mmio_wstrb),
    .mmio_rdata  (mmio_rdata),
    .mmio_ready  (mmio_ready),
    .spi_sck     (spi_sck),
    .spi_cs      (spi_cs),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe)
`ifdef SPI_SLAVE_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always #10 clk = ~clk;

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    vectors++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d);
    int n;
    tick(1);
    mmio_valid = 1'b1; mmio_write = 1'b1; mmio_addr = a; mmio_wdata = d; mmio_wstrb = 4'hF;
    n = 0;
    do begin tick(1); n++; end while (!mmio_ready && n < 8);
    mmio_valid = 1'b0; mmio_write = 1'b0; mmio_wstrb = 4'h0;
    vectors++;
    assert (mmio_ready === 1'b1) else begin
      errors++;
      $error("FAIL wr_ready %h: observed %b expected 1", a, mmio_ready);
    end
  endtask

  task automatic mmio_rd(input logic [31:0] a, input string tag);
    int n;
    tick(1);
    mmio_valid = 1'b1; mmio_write = 1'b0; mmio_addr = a;
    n = 0;
    do begin tick(1); n++; end while (!mmio_ready && n < 8);
    mmio_valid = 1'b0;
    check(tag, mmio_ready ? mmio_rdata : 32'hx);
  endtask

  task automatic half();
    tick(4);
  endtask

  // Controller side: nbits MSB-first in the current cpol/cpha mode
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        spi_mosi = tx[i];
        half();
        rx[i] = spi_miso;
        spi_sck = ~cpol;
        half();
        spi_sck = cpol;
      end else begin
        spi_sck = ~cpol;
        spi_mosi = tx[i];
        half();
        rx[i] = spi_miso;
        spi_sck = cpol;
        half();
      end
    end
    half();
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    spi_cs = 1'b1;
    tick(8);
  endtask

  task automatic set_mode(input logic [1:0] m);
    cpol = m[0];
    cpha = m[1];
    mmio_wr(A_CTRL, {29'h0, 1'b1, cpha, cpol});
    spi_sck = cpol;
    tick(8);
  endtask

  initial begin
    logic [7:0] rx;
    tick(4);
    reset = 1'b0;
    tick(1);

    // Reset state
    expect_val(32'h0); check("rst_ready", 32'(mmio_ready));
    expect_val(32'h0); check("rst_rdata", mmio_rdata);
    expect_val(32'h0); check("rst_miso", 32'(spi_miso));
    expect_val(32'h0); check("rst_oe", 32'(spi_miso_oe));
    expect_val(32'h0); mmio_rd(A_CTRL, "rst_ctrl");
    expect_val(32'h2); mmio_rd(A_STATUS, "rst_status");
    expect_val(32'h0); mmio_rd(32'h8000_0070, "unmapped_rd");

    // Mode 0: TX 0xA5, RX 0x3C
    set_mode(2'd0);
    mmio_wr(A_TXDATA, 32'hA5);
    expect_val(32'h0); mmio_rd(A_TXDATA, "txdata_rd");
    expect_val(32'h0); mmio_rd(A_STATUS, "m0_status_loaded");
    cs_low();
    expect_val(32'h1); check("m0_oe", 32'(spi_miso_oe));
    expect_val(32'h0A); mmio_rd(A_STATUS, "m0_status_cs");
    expect_val(32'hA5); spi_xfer(8'h3C, 8, rx); check("m0_miso", 32'(rx));
    cs_high();
    expect_val(32'h0); check("m0_oe_off", 32'(spi_miso_oe));
    expect_val(32'h03); mmio_rd(A_STATUS, "m0_status_done");
    expect_val(32'h3C); mmio_rd(A_RXDATA, "m0_rxdata");
    expect_val(32'h02); mmio_rd(A_STATUS, "m0_status_read");

    // Modes 1..3: TX 0x81, RX 0x7E
    for (int m = 1; m < 4; m++) begin
      set_mode(2'(m));
      mmio_wr(A_TXDATA, 32'h81);
      cs_low();
      expect_val(32'h81); spi_xfer(8'h7E, 8, rx); check($sformatf("m%0d_miso", m), 32'(rx));
      cs_high();
      expect_val(32'h7E); mmio_rd(A_RXDATA, $sformatf("m%0d_rxdata", m));
    end

    // Two-byte burst with empty TX holding register, overrun on second byte
    set_mode(2'd0);
    cs_low();
    expect_val(32'hFF); spi_xfer(8'h12, 8, rx); check("burst_miso0", 32'(rx));
    expect_val(32'hFF); spi_xfer(8'h34, 8, rx); check("burst_miso1", 32'(rx));
    cs_high();
    expect_val(32'h07); mmio_rd(A_STATUS, "ovr_status");
    expect_val(32'h34); mmio_rd(A_RXDATA, "ovr_rxdata");
    mmio_wr(A_STATUS, 32'h4);
    expect_val(32'h02); mmio_rd(A_STATUS, "ovr_cleared");

    // Aborted 5-bit transfer, then a full byte
    cs_low();
    spi_xfer(8'hF0, 5, rx);
    expect_val(32'h1A); mmio_rd(A_STATUS, "part_busy");
    cs_high();
    expect_val(32'h02); mmio_rd(A_STATUS, "part_status");
    cs_low();
    expect_val(32'hFF); spi_xfer(8'h55, 8, rx); check("part_next_miso", 32'(rx));
    cs_high();
    expect_val(32'h55); mmio_rd(A_RXDATA, "part_next_rx");

    // Reset in the middle of a byte
    mmio_wr(A_TXDATA, 32'hC3);
    cs_low();
    spi_xfer(8'hAA, 4, rx);
    expect_val(32'h1); check("pre_rst_oe", 32'(spi_miso_oe));
    reset = 1'b1;
    tick(1);
    expect_val(32'h0); check("midrst_miso", 32'(spi_miso));
    expect_val(32'h0); check("midrst_oe", 32'(spi_miso_oe));
    expect_val(32'h0); check("midrst_ready", 32'(mmio_ready));
    expect_val(32'h0); check("midrst_rdata", mmio_rdata);
    reset = 1'b0;
    spi_cs = 1'b1; spi_sck = 1'b0; cpol = 1'b0; cpha = 1'b0;
    tick(8);
    expect_val(32'h02); mmio_rd(A_STATUS, "midrst_status");
    expect_val(32'h0); mmio_rd(A_CTRL, "midrst_ctrl");

`ifdef SPI_SLAVE_IRQ_EN
    // Interrupt on received byte, cleared by RXDATA read
    mmio_wr(A_CTRL, 32'hC);
    tick(4);
    cs_low();
    spi_xfer(8'h99, 8, rx);
    cs_high();
    expect_val(32'h1); check("irq_set", 32'(irq));
    expect_val(32'h99); mmio_rd(A_RXDATA, "irq_rxdata");
    tick(2);
    expect_val(32'h0); check("irq_clr", 32'(irq));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
